// File: rtl/pipelined_shift_unit.sv
// rtl/pipelined_shift_unit.sv - pipelined logarithmic shifter (SLL/SRL/SRA/ROR) with handshake, tag and flush
module pipelined_shift_unit #(
   parameter int WIDTH     = 32,
   parameter int SHW       = 5,
   parameter int REG_EVERY = 1,
   parameter int TAG_W     = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);
   localparam int NSTG = (SHW + REG_EVERY - 1) / REG_EVERY;

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;

   // Stage registers; stage s holds the value after its group of mux levels.
   logic [NSTG-1:0]  r_valid;
   logic [WIDTH-1:0] r_data  [NSTG];
   logic [SHW-1:0]   r_shamt [NSTG];
   logic [1:0]       r_mode  [NSTG];
   logic [TAG_W-1:0] r_tag   [NSTG];
   logic             r_sign  [NSTG];

   // Source of each stage: the unit inputs for stage 0, the previous stage otherwise.
   logic [NSTG-1:0]  w_src_valid;
   logic [WIDTH-1:0] w_src_data  [NSTG];
   logic [SHW-1:0]   w_src_shamt [NSTG];
   logic [1:0]       w_src_mode  [NSTG];
   logic [TAG_W-1:0] w_src_tag   [NSTG];
   logic             w_src_sign  [NSTG];
   logic [WIDTH-1:0] w_shifted   [NSTG];
   logic [NSTG-1:0]  w_load;
   logic             w_chain;

   // One mux level: shift by amt (a power of two below WIDTH) in the requested mode.
   // The SRA fill is the operand sign captured at input, not the current top bit.
   function automatic logic [WIDTH-1:0] f_level(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       mode,
                                                input logic             sign,
                                                input int               amt);
      logic [WIDTH-1:0] hi_mask;
      hi_mask = ~({WIDTH{1'b1}} >> amt);
      case (mode)
         MODE_SLL: return d << amt;
         MODE_SRL: return d >> amt;
         MODE_SRA: return (d >> amt) | (sign ? hi_mask : '0);
         default:  return (d >> amt) | (d << (WIDTH - amt));
      endcase
   endfunction

   // Route inputs into stage 0 and each stage register into the next stage.
   always_comb begin
      w_src_valid[0] = in_valid;
      w_src_data[0]  = in_data;
      w_src_shamt[0] = in_shamt;
      w_src_mode[0]  = in_mode;
      w_src_tag[0]   = in_tag;
      w_src_sign[0]  = in_data[WIDTH-1];
      for (int s = 1; s < NSTG; s++) begin
         w_src_valid[s] = r_valid[s-1];
         w_src_data[s]  = r_data[s-1];
         w_src_shamt[s] = r_shamt[s-1];
         w_src_mode[s]  = r_mode[s-1];
         w_src_tag[s]   = r_tag[s-1];
         w_src_sign[s]  = r_sign[s-1];
      end
   end

   // Mux levels, MSB level first; level k belongs to stage (SHW-1-k)/REG_EVERY.
   always_comb begin
      for (int s = 0; s < NSTG; s++) begin
         w_shifted[s] = w_src_data[s];
         for (int k = SHW - 1; k >= 0; k--) begin
            if ((((SHW - 1 - k) / REG_EVERY) == s) && w_src_shamt[s][k])
               w_shifted[s] = f_level(w_shifted[s], w_src_mode[s], w_src_sign[s], 1 << k);
         end
      end
   end

   // Stage-enable chain from the output back: a stage loads when empty or when its successor loads.
   always_comb begin
      w_load  = '0;
      w_chain = out_ready;
      for (int s = NSTG - 1; s >= 0; s--) begin
         w_load[s] = ~r_valid[s] | w_chain;
         w_chain   = w_load[s];
      end
   end

   // Pipeline registers; payload only moves with a valid op so idle outputs never toggle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid <= '0;
         for (int s = 0; s < NSTG; s++) begin
            r_data[s]  <= '0;
            r_shamt[s] <= '0;
            r_mode[s]  <= '0;
            r_tag[s]   <= '0;
            r_sign[s]  <= 1'b0;
         end
      end else begin
         for (int s = 0; s < NSTG; s++) begin
            if (flush)
               r_valid[s] <= 1'b0;
            else if (w_load[s])
               r_valid[s] <= w_src_valid[s];
            if (w_load[s] && w_src_valid[s]) begin
               r_data[s]  <= w_shifted[s];
               r_shamt[s] <= w_src_shamt[s];
               r_mode[s]  <= w_src_mode[s];
               r_tag[s]   <= w_src_tag[s];
               r_sign[s]  <= w_src_sign[s];
            end
         end
      end
   end

   assign in_ready  = w_load[0];
   assign out_valid = r_valid[NSTG-1];
   assign out_data  = r_data[NSTG-1];
   assign out_tag   = r_tag[NSTG-1];

endmodule
